// File: rtl/result_ascii_serializer_if.sv
// Handshake bundle between the concatenator result, this serializer and the UART TX.
// The slave side is the serializer; the master side plays concatenator plus UART.
interface result_ascii_serializer_if #(
    parameter int DATA_W = 32
);
    logic              valid;
    logic [DATA_W-1:0] value;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              tx_done;
    logic              busy;
    logic              done;

    modport master (
        output valid, value, tx_done,
        input  tx_data, tx_start, busy, done
    );

    modport slave (
        input  valid, value, tx_done,
        output tx_data, tx_start, busy, done
    );
endinterface

// File: rtl/result_ascii_serializer.sv
// Converts a binary result to decimal ASCII with a sequential double-dabble and
// streams the bytes (optional '-', digits, optional terminator) to a UART TX.
module result_ascii_serializer #(
    parameter int         DATA_W    = 32,
    parameter int         N_DIGITS  = 10,
    parameter int         SIGNED    = 1,
    parameter int         TERM_EN   = 1,
    parameter logic [7:0] TERM_CHAR = 8'h0A
) (
    input  logic                           clk,
    input  logic                           reset,
    result_ascii_serializer_if.slave       bus
);
    localparam int BCD_W = 4 * N_DIGITS;
    localparam int PTR_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam logic [PTR_W-1:0]  PTR_TOP  = PTR_W'(N_DIGITS - 1);
    localparam logic [PTR_W-1:0]  PTR_ZERO = PTR_W'(0);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [DATA_W-1:0] VAL_ONE  = DATA_W'(1);

    typedef enum logic [3:0] {
        S_IDLE, S_ABS, S_CONV, S_SIGN, S_SIGN_WAIT, S_SKIP,
        S_SEND, S_WAIT, S_TERM, S_TERM_WAIT, S_FIN
    } state_t;

    state_t             r_state;
    logic [DATA_W-1:0]  r_value;
    logic               r_neg;
    logic [DATA_W-1:0]  r_mag;
    logic [BCD_W-1:0]   r_bcd;
    logic [CNT_W-1:0]   r_cnt;
    logic [PTR_W-1:0]   r_ptr;
    logic [7:0]         r_tx_data;
    logic               r_tx_start;
    logic               r_busy;
    logic               r_done;

    logic [BCD_W-1:0]   w_bcd_adj;
    logic [BCD_W-1:0]   w_bcd_next;
    logic [DATA_W-1:0]  w_mag_next;
    logic               w_neg;
    logic [PTR_W-1:0]   w_ptr_dec;
    logic [3:0]         w_top_conv;
    logic [3:0]         w_top_reg;
    logic [3:0]         w_dec_nib;

    function automatic logic [3:0] nibble_at(input logic [BCD_W-1:0] bcd,
                                             input logic [PTR_W-1:0] idx);
        logic [3:0] nib;
        nib = 4'h0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx == PTR_W'(i)) begin
                nib = bcd[i*4 +: 4];
            end
        end
        return nib;
    endfunction

    function automatic logic [7:0] ascii_digit(input logic [3:0] nib);
        return 8'h30 + {4'h0, nib};
    endfunction

    // One double-dabble step: add 3 to every nibble >= 5, then shift {bcd, mag} left.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (r_bcd[i*4 +: 4] >= 4'd5) begin
                w_bcd_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
            end else begin
                w_bcd_adj[i*4 +: 4] = r_bcd[i*4 +: 4];
            end
        end
        w_bcd_next = {w_bcd_adj[BCD_W-2:0], r_mag[DATA_W-1]};
        w_mag_next = {r_mag[DATA_W-2:0], 1'b0};
    end

    // Digit look-ahead so the first byte leaves without a wasted cycle when nothing is skipped.
    always_comb begin
        w_neg      = (SIGNED != 0) && r_value[DATA_W-1];
        w_ptr_dec  = r_ptr - PTR_ONE;
        w_top_conv = nibble_at(w_bcd_next, PTR_TOP);
        w_top_reg  = nibble_at(r_bcd, PTR_TOP);
        w_dec_nib  = nibble_at(r_bcd, w_ptr_dec);
    end

    // Control FSM with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_value    <= {DATA_W{1'b0}};
            r_neg      <= 1'b0;
            r_mag      <= {DATA_W{1'b0}};
            r_bcd      <= {BCD_W{1'b0}};
            r_cnt      <= {CNT_W{1'b0}};
            r_ptr      <= PTR_ZERO;
            r_tx_data  <= 8'h00;
            r_tx_start <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.valid) begin
                        r_value <= bus.value;
                        r_busy  <= 1'b1;
                        r_state <= S_ABS;
                    end
                end
                S_ABS: begin
                    r_neg   <= w_neg;
                    r_mag   <= w_neg ? ((~r_value) + VAL_ONE) : r_value;
                    r_bcd   <= {BCD_W{1'b0}};
                    r_cnt   <= {CNT_W{1'b0}};
                    r_state <= S_CONV;
                end
                S_CONV: begin
                    r_bcd <= w_bcd_next;
                    r_mag <= w_mag_next;
                    r_cnt <= r_cnt + CNT_ONE;
                    if (r_cnt == CNT_LAST) begin
                        r_ptr <= PTR_TOP;
                        if (r_neg) begin
                            r_tx_data  <= 8'h2D;
                            r_tx_start <= 1'b1;
                            r_state    <= S_SIGN;
                        end else if ((w_top_conv != 4'h0) || (PTR_TOP == PTR_ZERO)) begin
                            r_tx_data  <= ascii_digit(w_top_conv);
                            r_tx_start <= 1'b1;
                            r_state    <= S_SEND;
                        end else begin
                            r_state <= S_SKIP;
                        end
                    end
                end
                S_SIGN: begin
                    r_state <= S_SIGN_WAIT;
                end
                S_SIGN_WAIT: begin
                    if (bus.tx_done) begin
                        if ((w_top_reg != 4'h0) || (PTR_TOP == PTR_ZERO)) begin
                            r_tx_data  <= ascii_digit(w_top_reg);
                            r_tx_start <= 1'b1;
                            r_state    <= S_SEND;
                        end else begin
                            r_state <= S_SKIP;
                        end
                    end
                end
                S_SKIP: begin
                    r_ptr <= w_ptr_dec;
                    if ((w_dec_nib != 4'h0) || (w_ptr_dec == PTR_ZERO)) begin
                        r_tx_data  <= ascii_digit(w_dec_nib);
                        r_tx_start <= 1'b1;
                        r_state    <= S_SEND;
                    end
                end
                S_SEND: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.tx_done) begin
                        if (r_ptr == PTR_ZERO) begin
                            if (TERM_EN != 0) begin
                                r_tx_data  <= TERM_CHAR;
                                r_tx_start <= 1'b1;
                                r_state    <= S_TERM;
                            end else begin
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= S_FIN;
                            end
                        end else begin
                            r_ptr      <= w_ptr_dec;
                            r_tx_data  <= ascii_digit(w_dec_nib);
                            r_tx_start <= 1'b1;
                            r_state    <= S_SEND;
                        end
                    end
                end
                S_TERM: begin
                    r_state <= S_TERM_WAIT;
                end
                S_TERM_WAIT: begin
                    if (bus.tx_done) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.tx_data  = r_tx_data;
    assign bus.tx_start = r_tx_start;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;

endmodule

// File: tb/tb_result_ascii_serializer.sv
// Bench for result_ascii_serializer: signed and unsigned instances, each with a
// fixed-latency UART model, checked against a decimal-string reference model.
module tb_result_ascii_serializer;
    localparam int LAT = 20;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    result_ascii_serializer_if #(.DATA_W(32)) bus_s ();
    result_ascii_serializer_if #(.DATA_W(32)) bus_u ();

    result_ascii_serializer #(.DATA_W(32), .N_DIGITS(10), .SIGNED(1), .TERM_EN(1), .TERM_CHAR(8'h0A))
        dut_s (.clk(clk), .reset(reset), .bus(bus_s));
    result_ascii_serializer #(.DATA_W(32), .N_DIGITS(10), .SIGNED(0), .TERM_EN(1), .TERM_CHAR(8'h0A))
        dut_u (.clk(clk), .reset(reset), .bus(bus_u));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] q_s[$];
    int         t_s[$];
    int done_cnt_s, done_cyc_s, done_busy_s, busy_bad_s, stable_bad_s, ucnt_s;
    logic [7:0] q_u[$];
    int         t_u[$];
    int done_cnt_u, done_cyc_u, done_busy_u, busy_bad_u, stable_bad_u, ucnt_u;

    logic [7:0] exp_q[$];
    int         exp_k;
    bit         exp_neg;

    // Monitor plus UART model for the signed instance.
    always @(negedge clk) begin
        if (bus_s.tx_start === 1'b1) begin
            q_s.push_back(bus_s.tx_data);
            t_s.push_back(cyc);
            if (bus_s.busy !== 1'b1) busy_bad_s++;
        end
        if (bus_s.done === 1'b1) begin
            done_cnt_s++;
            done_cyc_s  = cyc;
            done_busy_s = int'(bus_s.busy);
        end
        bus_s.tx_done = 1'b0;
        if (ucnt_s > 0) begin
            ucnt_s--;
            if (ucnt_s == 0) begin
                bus_s.tx_done = 1'b1;
                if (q_s.size() > 0 && bus_s.tx_data !== q_s[q_s.size()-1]) stable_bad_s++;
            end
        end
        if (bus_s.tx_start === 1'b1) ucnt_s = LAT;
    end

    // Monitor plus UART model for the unsigned instance.
    always @(negedge clk) begin
        if (bus_u.tx_start === 1'b1) begin
            q_u.push_back(bus_u.tx_data);
            t_u.push_back(cyc);
            if (bus_u.busy !== 1'b1) busy_bad_u++;
        end
        if (bus_u.done === 1'b1) begin
            done_cnt_u++;
            done_cyc_u  = cyc;
            done_busy_u = int'(bus_u.busy);
        end
        bus_u.tx_done = 1'b0;
        if (ucnt_u > 0) begin
            ucnt_u--;
            if (ucnt_u == 0) begin
                bus_u.tx_done = 1'b1;
                if (q_u.size() > 0 && bus_u.tx_data !== q_u[q_u.size()-1]) stable_bad_u++;
            end
        end
        if (bus_u.tx_start === 1'b1) ucnt_u = LAT;
    end

    // Reference: decimal text of the value, optional '-', newline terminator.
    function automatic void model(input logic [31:0] v, input bit sgn);
        longint unsigned m;
        int d[$];
        exp_neg = sgn && v[31];
        m = exp_neg ? (64'd4294967296 - 64'(v)) : 64'(v);
        do begin
            d.push_front(int'(m % 64'd10));
            m = m / 64'd10;
        end while (m != 64'd0);
        exp_q.delete();
        if (exp_neg) exp_q.push_back(8'h2D);
        foreach (d[i]) exp_q.push_back(8'(8'h30 + d[i]));
        exp_q.push_back(8'h0A);
        exp_k = 10 - d.size();
    endfunction

    task automatic clear_s();
        q_s.delete(); t_s.delete();
        done_cnt_s = 0; busy_bad_s = 0; stable_bad_s = 0; done_busy_s = 1; done_cyc_s = -1;
    endtask

    task automatic pulse_valid_s(input logic [31:0] v, output int t0);
        @(negedge clk);
        bus_s.valid = 1'b1;
        bus_s.value = v;
        t0 = cyc;
        @(negedge clk);
        bus_s.valid = 1'b0;
    endtask

    task automatic wait_done_s(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done_cnt_s > 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic run_u(input logic [31:0] v, output int t0, output bit ok);
        q_u.delete(); t_u.delete();
        done_cnt_u = 0; busy_bad_u = 0; stable_bad_u = 0; done_busy_u = 1; done_cyc_u = -1;
        @(negedge clk);
        bus_u.valid = 1'b1;
        bus_u.value = v;
        t0 = cyc;
        @(negedge clk);
        bus_u.valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done_cnt_u > 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++; if (bus_s.tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data_s: got %h expected 00", bus_s.tx_data); end
        n_cmp++; if (bus_s.tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start_s: got %b expected 0", bus_s.tx_start); end
        n_cmp++; if (bus_s.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy_s: got %b expected 0", bus_s.busy); end
        n_cmp++; if (bus_s.done !== 1'b0) begin n_fail++; $display("FAIL reset_done_s: got %b expected 0", bus_s.done); end
        n_cmp++; if (bus_u.tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data_u: got %h expected 00", bus_u.tx_data); end
        n_cmp++; if (bus_u.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy_u: got %b expected 0", bus_u.busy); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_signed_stream();
        logic [31:0] vals[$];
        int t0, bad;
        bit ok;
        vals = '{32'd0, 32'd12345, 32'hFFFFFFF9, 32'h7FFFFFFF, 32'h80000000};
        for (int i = 0; i < 7; i++) begin
            logic [31:0] r;
            r = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) r = -r;
            vals.push_back(r);
        end
        foreach (vals[n]) begin
            model(vals[n], 1'b1);
            clear_s();
            pulse_valid_s(vals[n], t0);
            wait_done_s(ok);
            n_cmp++; if (!ok) begin n_fail++; $display("FAIL s_timeout: value %h got no done, expected done", vals[n]); end
            n_cmp++;
            if (q_s.size() != exp_q.size()) begin
                n_fail++; $display("FAIL s_len: value %h got %0d bytes expected %0d", vals[n], q_s.size(), exp_q.size());
            end else begin
                bad = 0;
                foreach (exp_q[j]) if (q_s[j] !== exp_q[j]) bad++;
                if (bad != 0) begin n_fail++; $display("FAIL s_bytes: value %h got %p expected %p", vals[n], q_s, exp_q); end
            end
            n_cmp++;
            if (t_s.size() == 0 || t_s[0] != t0 + 34 + (exp_neg ? 0 : exp_k)) begin
                n_fail++; $display("FAIL s_first_start: value %h got %0d expected %0d", vals[n],
                                   (t_s.size() > 0) ? t_s[0] - t0 : -1, 34 + (exp_neg ? 0 : exp_k));
            end
            bad = 0;
            for (int j = (exp_neg ? 2 : 1); j < t_s.size(); j++) if (t_s[j] != t_s[j-1] + LAT + 1) bad++;
            n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL s_gap: value %h got %0d late starts expected 0", vals[n], bad); end
            n_cmp++;
            if (t_s.size() == 0 || done_cyc_s != t_s[t_s.size()-1] + LAT + 1) begin
                n_fail++; $display("FAIL s_done_time: value %h got %0d expected last start + %0d", vals[n], done_cyc_s, LAT + 1);
            end
            n_cmp++; if (done_cnt_s != 1) begin n_fail++; $display("FAIL s_done_cnt: got %0d expected 1", done_cnt_s); end
            n_cmp++; if (done_busy_s != 0) begin n_fail++; $display("FAIL s_busy_at_done: got %0d expected 0", done_busy_s); end
            n_cmp++; if (busy_bad_s != 0) begin n_fail++; $display("FAIL s_busy_low: got %0d starts without busy expected 0", busy_bad_s); end
            n_cmp++; if (stable_bad_s != 0) begin n_fail++; $display("FAIL s_stable: got %0d changes expected 0", stable_bad_s); end
        end
    endtask

    task automatic test_unsigned();
        logic [31:0] vals[$];
        int t0, bad;
        bit ok;
        vals = '{32'hFFFFFFF9, 32'h80000000, 32'd7};
        for (int i = 0; i < 3; i++) vals.push_back($urandom);
        foreach (vals[n]) begin
            model(vals[n], 1'b0);
            run_u(vals[n], t0, ok);
            n_cmp++; if (!ok) begin n_fail++; $display("FAIL u_timeout: value %h got no done, expected done", vals[n]); end
            n_cmp++;
            if (q_u.size() != exp_q.size()) begin
                n_fail++; $display("FAIL u_len: value %h got %0d bytes expected %0d", vals[n], q_u.size(), exp_q.size());
            end else begin
                bad = 0;
                foreach (exp_q[j]) if (q_u[j] !== exp_q[j]) bad++;
                if (bad != 0) begin n_fail++; $display("FAIL u_bytes: value %h got %p expected %p", vals[n], q_u, exp_q); end
            end
            n_cmp++;
            if (t_u.size() == 0 || t_u[0] != t0 + 34 + exp_k) begin
                n_fail++; $display("FAIL u_first_start: value %h got %0d expected %0d", vals[n],
                                   (t_u.size() > 0) ? t_u[0] - t0 : -1, 34 + exp_k);
            end
            n_cmp++; if (done_cnt_u != 1 || done_busy_u != 0) begin
                n_fail++; $display("FAIL u_done: got count %0d busy %0d expected 1 and 0", done_cnt_u, done_busy_u);
            end
        end
    endtask

    task automatic test_ignored_valid();
        int t0, bad;
        bit ok;
        model(32'd12345, 1'b1);
        clear_s();
        pulse_valid_s(32'd12345, t0);
        repeat (8) @(negedge clk);
        bus_s.valid = 1'b1; bus_s.value = 32'd99;
        @(negedge clk);
        bus_s.valid = 1'b0;
        for (int i = 0; i < 500 && t_s.size() < 2; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        bus_s.valid = 1'b1; bus_s.value = 32'd99;
        @(negedge clk);
        bus_s.valid = 1'b0;
        wait_done_s(ok);
        repeat (150) @(negedge clk);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL ign_timeout: got no done expected done"); end
        n_cmp++; if (done_cnt_s != 1) begin n_fail++; $display("FAIL ign_done_cnt: got %0d expected 1", done_cnt_s); end
        n_cmp++;
        if (q_s.size() != exp_q.size()) begin
            n_fail++; $display("FAIL ign_len: got %0d bytes expected %0d", q_s.size(), exp_q.size());
        end else begin
            bad = 0;
            foreach (exp_q[j]) if (q_s[j] !== exp_q[j]) bad++;
            if (bad != 0) begin n_fail++; $display("FAIL ign_bytes: got %p expected %p", q_s, exp_q); end
        end
    endtask

    task automatic test_reset_midstream();
        int t0;
        bit ok;
        clear_s();
        pulse_valid_s(32'd12345, t0);
        for (int i = 0; i < 500 && t_s.size() < 3; i++) @(negedge clk);
        n_cmp++; if (t_s.size() != 3) begin n_fail++; $display("FAIL rst_reach: got %0d starts expected 3", t_s.size()); end
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus_s.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", bus_s.busy); end
        n_cmp++; if (bus_s.tx_start !== 1'b0) begin n_fail++; $display("FAIL rst_tx_start: got %b expected 0", bus_s.tx_start); end
        n_cmp++; if (bus_s.tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_tx_data: got %h expected 00", bus_s.tx_data); end
        reset = 1'b0;
        repeat (40) @(negedge clk);
        n_cmp++; if (done_cnt_s != 0) begin n_fail++; $display("FAIL rst_no_done: got %0d expected 0", done_cnt_s); end
        n_cmp++; if (t_s.size() != 3) begin n_fail++; $display("FAIL rst_no_more: got %0d starts expected 3", t_s.size()); end
        model(32'd5, 1'b1);
        clear_s();
        pulse_valid_s(32'd5, t0);
        wait_done_s(ok);
        n_cmp++; if (!ok || done_cnt_s != 1) begin n_fail++; $display("FAIL rst_after_done: got %0d expected 1", done_cnt_s); end
        n_cmp++;
        if (q_s.size() != 2 || q_s[0] !== exp_q[0] || q_s[1] !== exp_q[1]) begin
            n_fail++; $display("FAIL rst_after_bytes: got %p expected %p", q_s, exp_q);
        end
        n_cmp++;
        if (t_s.size() == 0 || t_s[0] != t0 + 43) begin
            n_fail++; $display("FAIL rst_after_start: got %0d expected 43", (t_s.size() > 0) ? t_s[0] - t0 : -1);
        end
    endtask

    initial begin
        bus_s.valid = 1'b0; bus_s.value = 32'd0;
        bus_u.valid = 1'b0; bus_u.value = 32'd0;
        ucnt_s = 0; ucnt_u = 0;
        clear_s();
        test_reset();
        test_signed_stream();
        test_unsigned();
        test_ignored_valid();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
